// File: rtl/seq_booth_multiplier_if.sv
// Handshake and result bundle between the requester (master) and seq_booth_multiplier (slave).
// The overflow signal exists only when SEQ_MUL_OVERFLOW_EN is defined.
interface seq_booth_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
`ifdef SEQ_MUL_OVERFLOW_EN
    logic                 overflow;
`endif

    modport master (
        output start, signed_mode, a, b,
`ifdef SEQ_MUL_OVERFLOW_EN
        input  overflow,
`endif
        input  ready, busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
`ifdef SEQ_MUL_OVERFLOW_EN
        output overflow,
`endif
        output ready, busy, done, product
    );
endinterface

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, one step per clock, signed or unsigned operands.
// Optional registered overflow flag enabled by defining SEQ_MUL_OVERFLOW_EN.
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_booth_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               ready, busy, done;
    logic               accept, last_step;

    logic [WIDTH:0]     a_ext, acc, sum, acc_step;
    logic [WIDTH+1:0]   q, q_step;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] product_r, result;
`ifdef SEQ_MUL_OVERFLOW_EN
    logic               sgn;
    logic               overflow_r;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial sums never exceed |a| in magnitude, so WIDTH+1 bits hold them exactly.
    always_comb begin
        case (q[1:0])
            2'b01:   sum = acc + a_ext;
            2'b10:   sum = acc - a_ext;
            default: sum = acc;
        endcase
        acc_step = {sum[WIDTH], sum[WIDTH:1]};
        q_step   = {sum[0], q[WIDTH+1:1]};
        result   = {acc_step[WIDTH-2:0], q_step[WIDTH+1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_ext      <= '0;
            acc        <= '0;
            q          <= '0;
            cnt        <= '0;
            product_r  <= '0;
`ifdef SEQ_MUL_OVERFLOW_EN
            sgn        <= 1'b0;
            overflow_r <= 1'b0;
`endif
        end else if (accept) begin
            a_ext <= {bus.signed_mode & bus.a[WIDTH-1], bus.a};
            acc   <= '0;
            q     <= {bus.signed_mode & bus.b[WIDTH-1], bus.b, 1'b0};
            cnt   <= CW'(WIDTH + 1);
`ifdef SEQ_MUL_OVERFLOW_EN
            sgn   <= bus.signed_mode;
`endif
        end else if (state == RUN) begin
            acc <= acc_step;
            q   <= q_step;
            cnt <= cnt - 1'b1;
            if (last_step) begin
                product_r <= result;
`ifdef SEQ_MUL_OVERFLOW_EN
                if (sgn)
                    overflow_r <= ~((&result[2*WIDTH-1:WIDTH-1]) | ~(|result[2*WIDTH-1:WIDTH-1]));
                else
                    overflow_r <= |result[2*WIDTH-1:WIDTH];
`endif
            end
        end
    end

    assign bus.ready   = ready;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_r;
`ifdef SEQ_MUL_OVERFLOW_EN
    assign bus.overflow = overflow_r;
`endif
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench for seq_booth_multiplier at WIDTH 32, 16 and 8 sharing one clock.
// Overflow is compared only when SEQ_MUL_OVERFLOW_EN is defined.
module tb_seq_booth_multiplier;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_booth_multiplier_if #(.WIDTH(32)) bus32();
    seq_booth_multiplier_if #(.WIDTH(16)) bus16();
    seq_booth_multiplier_if #(.WIDTH(8))  bus8();

    seq_booth_multiplier #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(bus32));
    seq_booth_multiplier #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(bus16));
    seq_booth_multiplier #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(bus8));

    typedef struct {
        logic [63:0] p;
        bit          ov;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t q8[$];
    int   checks = 0;
    int   failures = 0;
    int   done32 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic [63:0] ax, bx, p;
        ax = 64'(a);
        bx = 64'(b);
        if (sgn && a[w-1]) ax = ax - (64'd1 << w);
        if (sgn && b[w-1]) bx = bx - (64'd1 << w);
        p = ax * bx;
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    function automatic bit ov_model(input bit sgn, input logic [63:0] p, input int w);
        logic [63:0] top;
        if (sgn) begin
            top = p >> (w - 1);
            return !(top == 64'd0 || top == ((64'd1 << (w + 1)) - 64'd1));
        end
        return (p >> w) != 64'd0;
    endfunction

    // Scoreboard monitors: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus32.done === 1'b1) begin
            done32++;
            if (q32.size() == 0) check("done32_unexpected", 1, 0);
            else begin
                e = q32.pop_front();
                check("product32", bus32.product, e.p);
`ifdef SEQ_MUL_OVERFLOW_EN
                check("overflow32", 64'(bus32.overflow), 64'(e.ov));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus16.done === 1'b1) begin
            if (q16.size() == 0) check("done16_unexpected", 1, 0);
            else begin
                e = q16.pop_front();
                check("product16", 64'(bus16.product), e.p);
`ifdef SEQ_MUL_OVERFLOW_EN
                check("overflow16", 64'(bus16.overflow), 64'(e.ov));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus8.done === 1'b1) begin
            if (q8.size() == 0) check("done8_unexpected", 1, 0);
            else begin
                e = q8.pop_front();
                check("product8", 64'(bus8.product), e.p);
`ifdef SEQ_MUL_OVERFLOW_EN
                check("overflow8", 64'(bus8.overflow), 64'(e.ov));
`endif
            end
        end
    end

    function automatic logic get_ready(input int w);
        case (w)
            32:      return bus32.ready;
            16:      return bus16.ready;
            default: return bus8.ready;
        endcase
    endfunction

    // Waits for ready, drives one request for one edge, pushes the expectation.
    // Returns at accept edge + 1 time unit with start already deasserted.
    task automatic issue(input int w, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] p, input bit ov);
        int n = 0;
        @(negedge clk);
        while (get_ready(w) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("ready_timeout", 0, 1);
            return;
        end
        case (w)
            32: begin
                bus32.start = 1'b1; bus32.signed_mode = sgn; bus32.a = a; bus32.b = b;
                q32.push_back('{p, ov});
            end
            16: begin
                bus16.start = 1'b1; bus16.signed_mode = sgn; bus16.a = a[15:0]; bus16.b = b[15:0];
                q16.push_back('{p, ov});
            end
            default: begin
                bus8.start = 1'b1; bus8.signed_mode = sgn; bus8.a = a[7:0]; bus8.b = b[7:0];
                q8.push_back('{p, ov});
            end
        endcase
        @(posedge clk);
        #1;
        bus32.start = 1'b0;
        bus16.start = 1'b0;
        bus8.start  = 1'b0;
    endtask

    task automatic timed32(input string tag, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] p, input bit ov);
        int n = 0;
        int busyc;
        issue(32, sgn, a, b, p, ov);
        busyc = int'(bus32.busy);
        while (bus32.done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus32.busy === 1'b1) busyc++;
        end
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busyc), 64'd33);
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0 || q8.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        bit rdy_seen;
        logic [31:0] ra, rb;
        bit sgn;
        logic [63:0] p;

        bus32.start = 1'b0; bus32.signed_mode = 1'b0; bus32.a = '0; bus32.b = '0;
        bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.a = '0; bus16.b = '0;
        bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_ready", 64'(bus32.ready), 64'd1);
        check("rst_busy", 64'(bus32.busy), 64'd0);
        check("rst_done", 64'(bus32.done), 64'd0);
        check("rst_product", bus32.product, 64'd0);
`ifdef SEQ_MUL_OVERFLOW_EN
        check("rst_overflow", 64'(bus32.overflow), 64'd0);
`endif

        timed32("mul_7_m3", 1'b1, 32'd7, -32'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        issue(32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        issue(32, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        issue(32, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);

        issue(8, 1'b1, 32'h80, 32'h80, 64'h4000, 1'b1);
        issue(8, 1'b1, 32'd100, 32'hFF, 64'hFF9C, 1'b0);
        issue(8, 1'b0, 32'd16, 32'd16, 64'h0100, 1'b1);
        issue(8, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 1'b1);
        drain();

        // start held high through RUN/DONE must not queue a second op
        base = done32;
        issue(32, 1'b1, 32'd5, 32'd6, 64'd30, 1'b0);
        bus32.start = 1'b1; bus32.signed_mode = 1'b1; bus32.a = 32'd9; bus32.b = 32'd9;
        rdy_seen = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (bus32.ready === 1'b1) rdy_seen = 1'b1;
        end
        check("hold_ready_low", 64'(rdy_seen), 64'd0);
        @(negedge clk);
        check("hold_ready_back", 64'(bus32.ready), 64'd1);
        q32.push_back('{64'd81, 1'b0});
        @(posedge clk);
        #1 bus32.start = 1'b0;
        drain();
        check("hold_done_count", 64'(done32 - base), 64'd2);

        // reset after the 10th iteration discards the op
        base = done32;
        issue(32, 1'b1, 32'd123, 32'd456, 64'd56088, 1'b0);
        void'(q32.pop_back());
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("midrst_ready", 64'(bus32.ready), 64'd1);
        check("midrst_busy", 64'(bus32.busy), 64'd0);
        check("midrst_done", 64'(bus32.done), 64'd0);
        check("midrst_product", bus32.product, 64'd0);
        timed32("mul_12_m12", 1'b1, 32'd12, -32'sd12, 64'hFFFF_FFFF_FFFF_FF70, 1'b0);
        drain();
        check("midrst_done_count", 64'(done32 - base), 64'd1);

        for (int i = 0; i < 2000; i++) begin
            sgn = (i >= 1000);
            ra = $urandom & 32'hFFFF;
            rb = $urandom & 32'hFFFF;
            if ($urandom_range(0, 15) == 0) ra = 32'h8000;
            if ($urandom_range(0, 15) == 0) rb = 32'hFFFF;
            p = model(sgn, ra, rb, 16);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(16, sgn, ra, rb, p, ov_model(sgn, p, 16));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_booth_multiplier.md
# seq_booth_multiplier

Multi-cycle, parametrised radix-2 Booth multiplier: the sequential successor to the combinational `BoothsMultiplier`. It computes one iteration per clock, so the ALU's MUL path no longer sits on a 32-deep combinational chain. It accepts signed or unsigned operands of any width through a start/ready/done handshake and holds the full double-width product until the next operation. It is intended to sit in the EX stage behind a stall, with `ALU` issuing requests.

## Interface
- `WIDTH`, default 32: operand width in bits, minimum 4.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request; accepted only on an edge where `ready`=1.
- `signed_mode` input 1: 1 means operands are two's complement; 0 means unsigned. Sampled with `start`.
- `a` input WIDTH: multiplicand, sampled on the accept edge.
- `b` input WIDTH: multiplier, sampled on the accept edge.
- `ready` output 1: high in IDLE only.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse; high in DONE only.
- `product` output 2*WIDTH: result, registered and held.
- `overflow` output 1: present only with `SEQ_MUL_OVERFLOW_EN`; registered and held.

## Operation
- States are IDLE, RUN and DONE. Reset value is IDLE.
- Reset values: `ready`=1, `busy`=0, `done`=0, `product`=0, `overflow`=0.
- IDLE to RUN happens on an edge where `start`=1. On that edge the block:
  - latches `a` and `b`, extended to WIDTH+1 bits (sign-extended if `signed_mode`, zero-extended otherwise);
  - clears the WIDTH+1-bit accumulator;
  - loads the Q register as {b_ext, 0};
  - loads the iteration counter with WIDTH+1.
- RUN performs one Booth step per edge:
  - Q[1:0]=01 adds a_ext to the accumulator; Q[1:0]=10 subtracts it; 00 and 11 do nothing.
  - It then arithmetic-shifts {acc, Q} right by 1 and decrements the counter.
  - All arithmetic is WIDTH+1 bits, with carry out discarded.
- RUN to DONE happens on the edge that executes the final (WIDTH+1-th) step. On that edge the block:
  - writes `product` as the low 2*WIDTH bits of {acc, Q[WIDTH+1:1]};
  - writes `overflow` as well, when enabled.
- DONE to IDLE happens unconditionally on the next edge. `product` is held until the next accept edge; it is not cleared on accept.
- `start` in RUN or DONE is ignored, with no queuing. Operand changes after the accept edge have no effect.
- The result is exact for all inputs in both modes, including the most-negative × most-negative signed case, which gives 2^(2W-2).
- Reset asserted in any state, including mid-RUN, behaves as follows:
  - on that edge: IDLE, outputs at reset values, counter and registers cleared, and the in-flight operation discarded with no `done`;
  - `reset` has priority over `start` on the same edge.

## Timing
- Call the accept edge E0. Iterations execute on edges E1 through E(WIDTH+1).
- `done`=1 and a valid `product` appear in the cycle after E(WIDTH+1), which is WIDTH+1 cycles after E0. For WIDTH=32 that is 33 cycles.
- `ready` returns high one cycle after `done`.
- Minimum start-to-start interval is WIDTH+3 cycles.
- `busy` is high for exactly WIDTH+1 cycles per operation.
- There are no combinational paths from inputs to outputs.

## Configuration
- `SEQ_MUL_OVERFLOW_EN` defined:
  - adds the `overflow` port, registered on the final RUN edge;
  - signed mode: 1 if `product` does not fit in WIDTH-bit signed, i.e. the top WIDTH+1 bits are not all equal;
  - unsigned mode: 1 if `product[2*WIDTH-1:WIDTH]` is nonzero;
  - reset value 0, held like `product`.
- `SEQ_MUL_OVERFLOW_EN` undefined: the port and its logic are absent; everything else is identical.

## Test plan
- WIDTH=32, signed, a=7, b=-3 → `done` 33 cycles after accept; `product`=64'hFFFF_FFFF_FFFF_FFEB; `busy` high for 33 cycles.
- WIDTH=32, a=b=32'hFFFF_FFFF:
  - unsigned → `product`=64'hFFFF_FFFE_0000_0001;
  - signed → 64'h0000_0000_0000_0001.
- WIDTH=8, with macro defined:
  - signed -128×-128 → `product`=16'h4000, `overflow`=1;
  - signed 100×-1 → 16'hFF9C, `overflow`=0;
  - unsigned 16×16 → 16'h0100, `overflow`=1.
- WIDTH=32, signed 5×6 accepted, then `start` held high with a=9, b=9 throughout RUN:
  - `ready`=0 throughout; `product`=30; exactly one `done` pulse;
  - second op accepted only when `ready` returns, giving 81.
- WIDTH=32, reset asserted after the 10th iteration:
  - next cycle: `ready`=1, `busy`=0, `done`=0, `product`=0;
  - a following 12×-12 gives 64'hFFFF_FFFF_FFFF_FF70 with normal latency.
- WIDTH=16 random regression, 1000 signed plus 1000 unsigned ops with random idle gaps: `product` matches the reference model on every `done`.
